diff_commit_queue: RTL

- Parametrised successor to the single-lane difftest commit bridge.
- Accepts up to COMMIT_WIDTH retired-instruction records per cycle from the core's commit stage and compacts the valid lanes in lane order.
- Buffers them in a DEPTH-entry circular FIFO and drains one record per cycle to the single-lane difftest commit sink under a valid/ready handshake.
- Tags each drained record with a wrapping sequence index and reports overflow.

---
 rtl/diff_commit_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/diff_commit_queue.sv
// Multi-lane commit compactor feeding a single-lane difftest sink.
// Valid lanes are packed in lane order into a circular FIFO and drained one per cycle.
module diff_commit_queue #(
   parameter int COMMIT_WIDTH = 2,
   parameter int DEPTH        = 8,
   parameter int XLEN         = 64
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [COMMIT_WIDTH-1:0]      in_valid,
   input  logic [COMMIT_WIDTH*XLEN-1:0] in_pc,
   input  logic [COMMIT_WIDTH*32-1:0]   in_instr,
   input  logic [COMMIT_WIDTH-1:0]      in_skip,
   input  logic [COMMIT_WIDTH-1:0]      in_wen,
   input  logic [COMMIT_WIDTH*8-1:0]    in_wdest,
   input  logic [COMMIT_WIDTH*XLEN-1:0] in_wdata,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   out_index,
   output logic [XLEN-1:0]              out_pc,
   output logic [31:0]                  out_instr,
   output logic                         out_skip,
   output logic                         out_wen,
   output logic [7:0]                   out_wdest,
   output logic [XLEN-1:0]              out_wdata,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - COMMIT_WIDTH);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];
   logic            skip_mem_q  [DEPTH];
   logic            wen_mem_q   [DEPTH];
   logic [7:0]      wdest_mem_q [DEPTH];
   logic [XLEN-1:0] wdata_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    seq_q, seq_d;
   logic          ovf_q, ovf_d;

   logic [AW-1:0] waddr [COMMIT_WIDTH];
   logic [CW-1:0] grp_cnt;
   logic          enq_fire, deq_fire;

   // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
   always_comb begin
      grp_cnt = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         waddr[i] = wr_ptr_q + grp_cnt[AW-1:0];
         grp_cnt  = grp_cnt + CW'(in_valid[i]);
      end
   end

   assign in_ready  = (count_q <= RDY_MAX);
   assign out_valid = (count_q != '0);
   assign enq_fire  = in_ready && (grp_cnt != '0);
   assign deq_fire  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      count_d  = count_q;
      if (enq_fire) begin
         wr_ptr_d = wr_ptr_q + grp_cnt[AW-1:0];
         count_d  = count_d + grp_cnt;
      end
      if (deq_fire) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         seq_d    = seq_q + 8'd1;
         count_d  = count_d - CW'(1);
      end
      // A group arriving while not ready is dropped whole; flag sticks until reset.
      if (!in_ready && (|in_valid))
         ovf_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         seq_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset_n && enq_fire) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (in_valid[i]) begin
               pc_mem_q[waddr[i]]    <= in_pc[i*XLEN +: XLEN];
               instr_mem_q[waddr[i]] <= in_instr[i*32 +: 32];
               skip_mem_q[waddr[i]]  <= in_skip[i];
               wen_mem_q[waddr[i]]   <= in_wen[i];
               wdest_mem_q[waddr[i]] <= in_wdest[i*8 +: 8];
               wdata_mem_q[waddr[i]] <= in_wdata[i*XLEN +: XLEN];
            end
         end
      end
   end

   assign out_index = out_valid ? seq_q                 : '0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign out_skip  = out_valid ? skip_mem_q[rd_ptr_q]  : 1'b0;
   assign out_wen   = out_valid ? wen_mem_q[rd_ptr_q]   : 1'b0;
   assign out_wdest = out_valid ? wdest_mem_q[rd_ptr_q] : '0;
   assign out_wdata = out_valid ? wdata_mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule
